lector_fifos_salida: RTL and testbench
======================================

# lector_fifos_salida

Output-side reader for the four egress FIFOs (FIFOS_0..3) of the switching datapath. It watches each FIFO's empty and almost-full flags, issues single-cycle read enables, and captures the returned 10-bit word. The word is presented on a single valid/ready output stream tagged with its source channel. The block replaces the manual `rd_enb_FIFOS_x` pulsing at the egress boundary and keeps per-channel delivery counts for checking.

## Interface
- `DATA_W`, default 10: word width, identical to the FIFO data width.
- `CNT_W`, default 8: width of each per-channel delivery counter.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows new reads to start; a transfer already in flight always completes.
- `empty_FIFOS_0..3`  in  1 each  FIFO empty flags.
- `almost_full_FIFOS_0..3`  in  1 each  FIFO almost-full flags.
- `data_out_FIFOS_0..3`  in  DATA_W each  FIFO read data, valid in the cycle after `rd_enb`.
- `rd_enb_FIFOS_0..3`  out  1 each  read enables, one-hot or all zero, registered.
- `data_out`  out  DATA_W  captured word.
- `canal_out`  out  2  source channel of `data_out`.
- `valid_out`  out  1  `data_out`/`canal_out` valid.
- `ready_in`  in  1  downstream accepts the word; a handshake occurs on an edge where `valid_out` and `ready_in` are both 1.
- `cnt_0..3`  out  CNT_W each  words delivered per channel.
- `idle`  out  1  FSM is in IDLE.

## Operation
- FSM states, encoded in registers:
  - IDLE: `idle`=1, all outputs quiet.
  - READ: `rd_enb_FIFOS_sel`=1 for exactly this cycle.
  - LOAD: `data_out_FIFOS_sel` is sampled at the end of the cycle into `data_out`; `canal_out` is set to `sel`.
  - SEND: `valid_out`=1; `data_out` and `canal_out` are held stable.
- Candidate set: channels with `empty`=0.
  - If any candidate is also almost-full, `sel` is the lowest-index almost-full candidate.
  - Otherwise `sel` is chosen round-robin, starting at `(last+1) mod 4`.
  - `last` is the channel of the most recent handshake.
- Transitions:
  - IDLE → READ when `enable`=1 and the candidate set is non-empty; `sel` is latched on that edge.
  - READ → LOAD, unconditional.
  - LOAD → SEND, unconditional.
  - SEND with `ready_in`=1: go to READ if `enable`=1 and a candidate exists (new `sel` latched), else go to IDLE.
  - SEND with `ready_in`=0: stay in SEND.
- Flag sampling: flags are sampled only at IDLE→READ and SEND→READ decisions. Flag changes during READ/LOAD do not abort the transfer.
- On handshake:
  - `cnt_sel` increments by 1, wrapping from 2^CNT_W−1 to 0.
  - `last` is set to `sel`.
- Never more than one word in flight, and never more than one `rd_enb` asserted at a time.
- `enable` falling during READ/LOAD/SEND: the current word is still delivered; the FSM then returns to IDLE.
- Reset values (asynchronous, at any point):
  - state=IDLE, `idle`=1.
  - `rd_enb_FIFOS_*`=0, `valid_out`=0, `data_out`=0, `canal_out`=0.
  - `cnt_*`=0, `last`=3, so the first round-robin search starts at channel 0.
  - A word in flight is discarded.
- `ready_in` is ignored outside SEND.

## Timing
- Edge k: IDLE→READ decision. `rd_enb` is high during cycle k..k+1.
- FIFO data is present during LOAD and captured at edge k+2.
- `valid_out` rises after edge k+2, giving 2 cycles from the `rd_enb` rising edge to `valid_out` rising.
- Back-to-back with `ready_in` held at 1: one word every 3 cycles, with no IDLE cycle between words.
- `rd_enb` is a registered output: at most one pulse per word, width exactly one cycle.
- Counters update on the handshake edge and are visible in the next cycle.

## Test plan
- **Reset:** `rst`=1 mid-SEND with `valid_out`=1 → all outputs immediately 0, `idle`=1, `cnt_*`=0. After release with `enable`=0, nothing moves.
- **Single word:** only FIFOS_2 non-empty, returning 10'b1010111110, `ready_in`=1.
  - `rd_enb_FIFOS_2` is high for one cycle.
  - Two cycles later: `valid_out`=1, `data_out`=10'b1010111110, `canal_out`=2.
  - `cnt_2`=1 after the handshake.
- **Round-robin:** all four FIFOs non-empty, no almost-full, `ready_in`=1 → service order 0,1,2,3,0; one read every 3 cycles.
- **Almost-full priority:** all non-empty; `almost_full_FIFOS_3`=1 asserted after channel 0 is served → next served is 3, then round-robin resumes at 0.
- **Backpressure:** `ready_in`=0 for 5 cycles during SEND → `valid_out`, `data_out` and `canal_out` stay stable, no `rd_enb` pulses, counter unchanged. `ready_in`=1 → exactly one handshake.
- **Enable drop and counter wrap:**
  - `enable` deasserted during READ → word is still delivered, then `idle`=1 with no further reads.
  - With CNT_W=2, four deliveries on channel 1 → `cnt_1` reads 1,2,3,0.

Source files
------------

// File: rtl/lector_fifos_salida.sv
// Egress reader: picks a non-empty FIFO, pulses its read enable and streams the word out tagged with its channel.
// Latency: 2 cycles from the rd_enb rising edge to valid_out; one word every 3 cycles back-to-back.
// Backpressure: the word is held in SEND while ready_in=0; no new read starts until the handshake.
module lector_fifos_salida #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty_FIFOS_0,
  input  logic              empty_FIFOS_1,
  input  logic              empty_FIFOS_2,
  input  logic              empty_FIFOS_3,
  input  logic              almost_full_FIFOS_0,
  input  logic              almost_full_FIFOS_1,
  input  logic              almost_full_FIFOS_2,
  input  logic              almost_full_FIFOS_3,
  input  logic [DATA_W-1:0] data_out_FIFOS_0,
  input  logic [DATA_W-1:0] data_out_FIFOS_1,
  input  logic [DATA_W-1:0] data_out_FIFOS_2,
  input  logic [DATA_W-1:0] data_out_FIFOS_3,
  output logic              rd_enb_FIFOS_0,
  output logic              rd_enb_FIFOS_1,
  output logic              rd_enb_FIFOS_2,
  output logic              rd_enb_FIFOS_3,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        canal_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic [CNT_W-1:0]  cnt_3,
  output logic              idle
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];
  logic [3:0]        rd_enb_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        canal_q;
  logic              valid_q;

  logic [3:0]        cand;
  logic [3:0]        af_cand;
  logic              any_cand;
  logic [DATA_W-1:0] fifo_dat [4];
  logic [1:0]        rr_base;
  logic [1:0]        rr_idx;
  logic [1:0]        pick;
  logic              found;

  assign cand     = ~{empty_FIFOS_3, empty_FIFOS_2, empty_FIFOS_1, empty_FIFOS_0};
  assign af_cand  = cand & {almost_full_FIFOS_3, almost_full_FIFOS_2,
                            almost_full_FIFOS_1, almost_full_FIFOS_0};
  assign any_cand = |cand;

  assign fifo_dat[0] = data_out_FIFOS_0;
  assign fifo_dat[1] = data_out_FIFOS_1;
  assign fifo_dat[2] = data_out_FIFOS_2;
  assign fifo_dat[3] = data_out_FIFOS_3;

  // Leaving SEND implies a handshake on the same edge, so that channel becomes the round-robin reference.
  assign rr_base = (state_q == SEND) ? sel_q : last_q;

  // Arbiter: lowest almost-full candidate wins, otherwise first candidate after rr_base.
  always_comb begin
    pick   = 2'd0;
    found  = 1'b0;
    rr_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && af_cand[i]) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
    for (int i = 1; i <= 4; i++) begin
      rr_idx = rr_base + 2'(i);
      if (!found && cand[rr_idx]) begin
        pick  = rr_idx;
        found = 1'b1;
      end
    end
  end

  // Next-state, channel selection and handshake bookkeeping.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable && any_cand) begin
          state_d = READ;
          sel_d   = pick;
        end
      end
      READ: state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (ready_in) begin
          last_d         = sel_q;
          cnt_d[sel_q]   = cnt_q[sel_q] + CNT_W'(1);
          if (enable && any_cand) begin
            state_d = READ;
            sel_d   = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      last_q   <= 2'd3;
      rd_enb_q <= 4'b0000;
      data_q   <= '0;
      canal_q  <= 2'd0;
      valid_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_enb_q <= (state_d == READ) ? (4'b0001 << sel_d) : 4'b0000;
      valid_q  <= (state_d == SEND);
      if (state_q == LOAD) begin
        data_q  <= fifo_dat[sel_q];
        canal_q <= sel_q;
      end
    end
  end

  assign rd_enb_FIFOS_0 = rd_enb_q[0];
  assign rd_enb_FIFOS_1 = rd_enb_q[1];
  assign rd_enb_FIFOS_2 = rd_enb_q[2];
  assign rd_enb_FIFOS_3 = rd_enb_q[3];
  assign data_out       = data_q;
  assign canal_out      = canal_q;
  assign valid_out      = valid_q;
  assign cnt_0          = cnt_q[0];
  assign cnt_1          = cnt_q[1];
  assign cnt_2          = cnt_q[2];
  assign cnt_3          = cnt_q[3];
  assign idle           = (state_q == IDLE);

endmodule

// File: tb/tb_lector_fifos_salida.sv
// Bench for lector_fifos_salida: directed stimulus, scoreboard of expected {channel, word} per handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
// Counters are built 2 bits wide so that wrap-around is reachable in a few words.
module tb_lector_fifos_salida;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [3:0]        empty;
  logic [3:0]        af;
  logic [DATA_W-1:0] fdat [4];
  logic [DATA_W-1:0] word [4];
  logic              rd_enb_FIFOS_0, rd_enb_FIFOS_1, rd_enb_FIFOS_2, rd_enb_FIFOS_3;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        canal_out;
  logic              valid_out;
  logic              ready_in;
  logic [CNT_W-1:0]  cnt_0, cnt_1, cnt_2, cnt_3;
  logic              idle;
  logic [3:0]        rd;

  int                nvec = 0;
  int                nmis = 0;
  logic [11:0]       exp_q [$];
  bit                multi_rd = 1'b0;

  always #5 clk = ~clk;

  assign rd = {rd_enb_FIFOS_3, rd_enb_FIFOS_2, rd_enb_FIFOS_1, rd_enb_FIFOS_0};

  lector_fifos_salida #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .empty_FIFOS_0       (empty[0]),
    .empty_FIFOS_1       (empty[1]),
    .empty_FIFOS_2       (empty[2]),
    .empty_FIFOS_3       (empty[3]),
    .almost_full_FIFOS_0 (af[0]),
    .almost_full_FIFOS_1 (af[1]),
    .almost_full_FIFOS_2 (af[2]),
    .almost_full_FIFOS_3 (af[3]),
    .data_out_FIFOS_0    (fdat[0]),
    .data_out_FIFOS_1    (fdat[1]),
    .data_out_FIFOS_2    (fdat[2]),
    .data_out_FIFOS_3    (fdat[3]),
    .rd_enb_FIFOS_0      (rd_enb_FIFOS_0),
    .rd_enb_FIFOS_1      (rd_enb_FIFOS_1),
    .rd_enb_FIFOS_2      (rd_enb_FIFOS_2),
    .rd_enb_FIFOS_3      (rd_enb_FIFOS_3),
    .data_out            (data_out),
    .canal_out           (canal_out),
    .valid_out           (valid_out),
    .ready_in            (ready_in),
    .cnt_0               (cnt_0),
    .cnt_1               (cnt_1),
    .cnt_2               (cnt_2),
    .cnt_3               (cnt_3),
    .idle                (idle)
  );

  // FIFO read port model: data only appears in the cycle after its read enable, zero otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      fdat[i] <= rd[i] ? word[i] : '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && ($countones(rd) > 1)) multi_rd = 1'b1;
    if (!rst && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", {20'd0, canal_out, data_out}, 32'hFFFFFFFF);
      end else begin
        chk("sb_word", {20'd0, canal_out, data_out}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that started READ for ch; leaves just after the handshake edge.
  task automatic do_word(input int ch, input bit drop_en);
    chk("rd_enb_onehot", {28'd0, rd}, 32'(4'b0001 << ch));
    if (drop_en) enable = 1'b0;
    tick();
    chk("load_rd_low", {28'd0, rd}, 32'd0);
    chk("load_valid_low", {31'd0, valid_out}, 32'd0);
    tick();
    chk("send_valid", {31'd0, valid_out}, 32'd1);
    chk("send_canal", {30'd0, canal_out}, 32'(ch));
    chk("send_data", {22'd0, data_out}, {22'd0, word[ch]});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    ready_in = 1'b0;
    empty    = 4'b1111;
    af       = 4'b0000;
    word[0]  = 10'h155;
    word[1]  = 10'h2AA;
    word[2]  = 10'b1010111110;
    word[3]  = 10'h0F3;
    tick();
    tick();
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_rd", {28'd0, rd}, 32'd0);
    chk("rst_data", {22'd0, data_out}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_3, cnt_2, cnt_1, cnt_0}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word from FIFOS_2.
    empty[2] = 1'b0;
    enable   = 1'b1;
    ready_in = 1'b1;
    exp_q.push_back({2'd2, word[2]});
    tick();
    chk("single_idle_low", {31'd0, idle}, 32'd0);
    empty[2] = 1'b1;
    do_word(2, 1'b0);
    chk("single_cnt2", {30'd0, cnt_2}, 32'd1);
    chk("single_idle_after", {31'd0, idle}, 32'd1);
    chk("single_valid_after", {31'd0, valid_out}, 32'd0);

    // Round-robin from a fresh reset: 0,1,2,3,0; enable dropped during the last READ.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    empty = 4'b0000;
    for (int k = 0; k < 5; k++) exp_q.push_back({2'(k % 4), word[k % 4]});
    tick();
    for (int k = 0; k < 5; k++) do_word(k % 4, k == 4);
    chk("rr_idle", {31'd0, idle}, 32'd1);
    chk("rr_cnts", {24'd0, cnt_3, cnt_2, cnt_1, cnt_0}, {24'd0, 2'd1, 2'd1, 2'd1, 2'd2});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_no_more_rd", {28'd0, rd}, 32'd0);
    end

    // Almost-full priority: last served was 0, FIFOS_3 almost full -> 3, then 0, 1.
    enable = 1'b1;
    af[3]  = 1'b1;
    exp_q.push_back({2'd3, word[3]});
    exp_q.push_back({2'd0, word[0]});
    exp_q.push_back({2'd1, word[1]});
    tick();
    af[3] = 1'b0;
    do_word(3, 1'b0);
    do_word(0, 1'b0);
    do_word(1, 1'b1);
    chk("af_idle", {31'd0, idle}, 32'd1);

    // Backpressure on a single word from FIFOS_1.
    empty    = 4'b1101;
    enable   = 1'b1;
    ready_in = 1'b0;
    exp_q.push_back({2'd1, word[1]});
    tick();
    chk("bp_rd", {28'd0, rd}, 32'b0010);
    empty[1] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, valid_out}, 32'd1);
      chk("bp_data", {22'd0, data_out}, {22'd0, word[1]});
      chk("bp_canal", {30'd0, canal_out}, 32'd1);
      chk("bp_rd_quiet", {28'd0, rd}, 32'd0);
      chk("bp_cnt1_hold", {30'd0, cnt_1}, 32'd2);
      tick();
    end
    ready_in = 1'b1;
    tick();
    chk("bp_cnt1", {30'd0, cnt_1}, 32'd3);
    chk("bp_idle", {31'd0, idle}, 32'd1);
    chk("bp_valid_drop", {31'd0, valid_out}, 32'd0);

    // Reset while a word sits in SEND: outputs clear at once, word discarded.
    empty[0] = 1'b0;
    ready_in = 1'b0;
    tick();
    chk("rs_rd", {28'd0, rd}, 32'b0001);
    empty[0] = 1'b1;
    tick();
    tick();
    chk("rs_valid_before", {31'd0, valid_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_valid", {31'd0, valid_out}, 32'd0);
    chk("rs_idle", {31'd0, idle}, 32'd1);
    chk("rs_data_canal", {20'd0, canal_out, data_out}, 32'd0);
    chk("rs_cnt", {24'd0, cnt_3, cnt_2, cnt_1, cnt_0}, 32'd0);
    tick();
    rst    = 1'b0;
    enable = 1'b0;
    empty  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rs_quiet_idle", {27'd0, idle, rd}, 32'h10);
    end

    // Counter wrap on channel 1 with CNT_W=2: 1,2,3,0.
    empty    = 4'b1101;
    enable   = 1'b1;
    ready_in = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      word[1] = 10'(10'h100 + k);
      exp_q.push_back({2'd1, word[1]});
      do_word(1, k == 3);
      chk("wrap_cnt1", {30'd0, cnt_1}, 32'((k + 1) % 4));
    end
    chk("wrap_idle", {31'd0, idle}, 32'd1);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_never_multi", {31'd0, multi_rd}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
